// File: rtl/mutative_types.sv
// Shared types and constants for the mutative cache memory-side blocks.
package mutative_types;

  // Width of one cacheline as seen on the downstream memory port.
  localparam int CACHELINE_SIZE = 256;

  // States of the downstream-port arbiter.
  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_BUSY_CACHE = 2'd1,
    ARB_BUSY_FLUSH = 2'd2
  } arb_state_e;

  // Encoding of the requester that owns the downstream port.
  localparam logic OWNER_CACHE = 1'b0;
  localparam logic OWNER_FLUSH = 1'b1;

endpackage

// File: rtl/mutative_dfp_arbiter.sv
// Two-way round-robin arbiter sharing the downstream memory port between the
// cache miss/eviction path and the flush writeback path. Holds one transaction
// at a time: the grant is issued combinationally in IDLE and held until the
// downstream completion pulse, which is routed back to the owner only.
module mutative_dfp_arbiter
  import mutative_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = CACHELINE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  // cache requester
  input  logic [ADDR_WIDTH-1:0] cache_dfp_addr,
  input  logic                  cache_dfp_read,
  input  logic                  cache_dfp_write,
  input  logic [LINE_WIDTH-1:0] cache_dfp_wdata,
  output logic [LINE_WIDTH-1:0] cache_dfp_rdata,
  output logic                  cache_dfp_resp,
  // flush requester (write-only)
  input  logic [ADDR_WIDTH-1:0] flush_dfp_addr,
  input  logic                  flush_dfp_write,
  input  logic [LINE_WIDTH-1:0] flush_dfp_wdata,
  output logic                  flush_dfp_resp,
  // downstream memory port
  output logic [ADDR_WIDTH-1:0] dfp_addr,
  output logic                  dfp_read,
  output logic                  dfp_write,
  output logic [LINE_WIDTH-1:0] dfp_wdata,
  input  logic [LINE_WIDTH-1:0] dfp_rdata,
  input  logic                  dfp_resp,
  // status
  output logic                  arb_busy,
  output logic                  arb_owner,
  output logic                  protocol_err
);

  // Round-robin choice between two requesters: a lone requester wins,
  // on a tie the one that did not own the port last time wins.
  function automatic logic rr_pick(input logic c_req, input logic f_req,
                                   input logic last);
    if (c_req && f_req) return (last == OWNER_CACHE) ? OWNER_FLUSH : OWNER_CACHE;
    else if (f_req)     return OWNER_FLUSH;
    else                return OWNER_CACHE;
  endfunction

  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic                  protocol_err_q, protocol_err_d;

  logic cache_req, flush_req;
  logic grant_valid, grant_owner;
  logic sel_valid, sel_owner;
  logic cache_resp_c, flush_resp_c;
  logic err_event;

  assign cache_req = cache_dfp_read | cache_dfp_write;
  assign flush_req = flush_dfp_write;

  // Next-state, grant selection, response routing and protocol checks.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_valid  = 1'b0;
    grant_owner  = OWNER_CACHE;
    sel_valid    = 1'b0;
    sel_owner    = OWNER_CACHE;
    cache_resp_c = 1'b0;
    flush_resp_c = 1'b0;
    err_event    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (cache_req || flush_req) begin
          grant_valid = 1'b1;
          grant_owner = rr_pick(cache_req, flush_req, last_grant_q);
          sel_valid   = 1'b1;
          sel_owner   = grant_owner;
          state_d     = (grant_owner == OWNER_FLUSH) ? ARB_BUSY_FLUSH : ARB_BUSY_CACHE;
        end
        // A completion with nothing outstanding is dropped and flagged.
        if (dfp_resp) err_event = 1'b1;
      end
      ARB_BUSY_CACHE: begin
        sel_valid = 1'b1;
        sel_owner = OWNER_CACHE;
        if (dfp_resp) begin
          cache_resp_c = 1'b1;
          last_grant_d = OWNER_CACHE;
          state_d      = ARB_IDLE;
        end else if (!cache_req) begin
          err_event = 1'b1;
        end
      end
      ARB_BUSY_FLUSH: begin
        sel_valid = 1'b1;
        sel_owner = OWNER_FLUSH;
        if (dfp_resp) begin
          flush_resp_c = 1'b1;
          last_grant_d = OWNER_FLUSH;
          state_d      = ARB_IDLE;
        end else if (!flush_req) begin
          err_event = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Simultaneous read and write from the cache is forwarded but flagged.
    if (cache_dfp_read && cache_dfp_write) err_event = 1'b1;

    owner_d        = grant_valid ? grant_owner : owner_q;
    rdata_d        = cache_resp_c ? dfp_rdata : rdata_q;
    protocol_err_d = protocol_err_q | err_event;
  end

  // Downstream mux and requester-facing outputs; forced to reset values while rst is high.
  always_comb begin
    dfp_addr        = '0;
    dfp_read        = 1'b0;
    dfp_write       = 1'b0;
    dfp_wdata       = '0;
    cache_dfp_resp  = 1'b0;
    flush_dfp_resp  = 1'b0;
    cache_dfp_rdata = '0;
    arb_busy        = 1'b0;
    arb_owner       = OWNER_CACHE;
    protocol_err    = 1'b0;

    if (!rst) begin
      if (sel_valid) begin
        if (sel_owner == OWNER_FLUSH) begin
          dfp_addr  = flush_dfp_addr;
          dfp_write = flush_dfp_write;
          dfp_wdata = flush_dfp_wdata;
        end else begin
          dfp_addr  = cache_dfp_addr;
          dfp_read  = cache_dfp_read;
          dfp_write = cache_dfp_write;
          dfp_wdata = cache_dfp_wdata;
        end
      end
      cache_dfp_resp  = cache_resp_c;
      flush_dfp_resp  = flush_resp_c;
      cache_dfp_rdata = rdata_d;
      arb_busy        = (state_q != ARB_IDLE) | grant_valid;
      arb_owner       = owner_d;
      protocol_err    = protocol_err_q;
    end
  end

  // State, round-robin history, owner, returned read data and sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q        <= ARB_IDLE;
      last_grant_q   <= OWNER_FLUSH;
      owner_q        <= OWNER_CACHE;
      rdata_q        <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      rdata_q        <= rdata_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_mutative_dfp_arbiter.sv
// Directed self-checking bench for the downstream-port arbiter.
module tb_mutative_dfp_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cache_dfp_addr;
  logic          cache_dfp_read, cache_dfp_write;
  logic [LW-1:0] cache_dfp_wdata, cache_dfp_rdata;
  logic          cache_dfp_resp;
  logic [AW-1:0] flush_dfp_addr;
  logic          flush_dfp_write;
  logic [LW-1:0] flush_dfp_wdata;
  logic          flush_dfp_resp;
  logic [AW-1:0] dfp_addr;
  logic          dfp_read, dfp_write;
  logic [LW-1:0] dfp_wdata, dfp_rdata;
  logic          dfp_resp;
  logic          arb_busy, arb_owner, protocol_err;

  int errors = 0;
  int checks = 0;

  localparam logic [LW-1:0] LINE_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] LINE_3C = {32{8'h3C}};
  localparam logic [LW-1:0] WD_F    = {8{32'hF00D_0001}};

  always #5 clk = ~clk;

  mutative_dfp_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cache_dfp_addr(cache_dfp_addr), .cache_dfp_read(cache_dfp_read),
    .cache_dfp_write(cache_dfp_write), .cache_dfp_wdata(cache_dfp_wdata),
    .cache_dfp_rdata(cache_dfp_rdata), .cache_dfp_resp(cache_dfp_resp),
    .flush_dfp_addr(flush_dfp_addr), .flush_dfp_write(flush_dfp_write),
    .flush_dfp_wdata(flush_dfp_wdata), .flush_dfp_resp(flush_dfp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .arb_busy(arb_busy), .arb_owner(arb_owner), .protocol_err(protocol_err)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    cache_dfp_read  = 1'b0;
    cache_dfp_write = 1'b0;
    flush_dfp_write = 1'b0;
    dfp_resp        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    cache_dfp_addr  = '0;
    cache_dfp_wdata = '0;
    flush_dfp_addr  = '0;
    flush_dfp_wdata = '0;
    dfp_rdata       = '0;
    do_reset();

    // Reset state
    check("rst_busy",  arb_busy, 0);
    check("rst_owner", arb_owner, 0);
    check("rst_err",   protocol_err, 0);
    check("rst_read",  dfp_read, 0);
    check("rst_write", dfp_write, 0);
    check("rst_addr",  dfp_addr, 0);
    check("rst_rdata", cache_dfp_rdata, 0);

    // Single cache read, response after 5 cycles
    cache_dfp_addr = 32'h0000_1040;
    cache_dfp_read = 1'b1;
    settle();
    check("rd_read",  dfp_read, 1);
    check("rd_addr",  dfp_addr, 32'h0000_1040);
    check("rd_busy",  arb_busy, 1);
    check("rd_owner", arb_owner, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rd_wait_cresp", cache_dfp_resp, 0);
      check("rd_wait_fresp", flush_dfp_resp, 0);
      check("rd_wait_read",  dfp_read, 1);
    end
    step();
    dfp_resp  = 1'b1;
    dfp_rdata = LINE_A5;
    settle();
    check("rd_cresp", cache_dfp_resp, 1);
    check("rd_rdata", cache_dfp_rdata, LINE_A5);
    check("rd_fresp", flush_dfp_resp, 0);
    step();
    dfp_resp       = 1'b0;
    cache_dfp_read = 1'b0;
    dfp_rdata      = '0;
    settle();
    check("rd_cresp_once", cache_dfp_resp, 0);
    check("rd_rdata_hold", cache_dfp_rdata, LINE_A5);
    check("rd_idle",       arb_busy, 0);

    // Flush write while cache idle
    flush_dfp_addr  = 32'h0000_2000;
    flush_dfp_wdata = WD_F;
    flush_dfp_write = 1'b1;
    settle();
    check("fw_write", dfp_write, 1);
    check("fw_addr",  dfp_addr, 32'h0000_2000);
    check("fw_wdata", dfp_wdata, WD_F);
    check("fw_owner", arb_owner, 1);
    step();
    step();
    dfp_resp = 1'b1;
    settle();
    check("fw_fresp", flush_dfp_resp, 1);
    check("fw_cresp", cache_dfp_resp, 0);
    step();
    idle_inputs();
    settle();
    check("fw_owner_hold", arb_owner, 1);

    // Simultaneous requests after reset: cache first, then flush, then cache again
    do_reset();
    cache_dfp_addr  = 32'h0000_3000;
    cache_dfp_read  = 1'b1;
    flush_dfp_addr  = 32'h0000_4000;
    flush_dfp_write = 1'b1;
    settle();
    check("tie_owner", arb_owner, 0);
    check("tie_addr",  dfp_addr, 32'h0000_3000);
    check("tie_read",  dfp_read, 1);
    check("tie_write", dfp_write, 0);
    step();
    dfp_resp  = 1'b1;
    dfp_rdata = LINE_3C;
    settle();
    check("tie_cresp", cache_dfp_resp, 1);
    check("tie_fresp", flush_dfp_resp, 0);
    step();
    dfp_resp       = 1'b0;
    cache_dfp_addr = 32'h0000_3040;   // cache re-requests immediately
    settle();
    check("rr_owner", arb_owner, 1);
    check("rr_addr",  dfp_addr, 32'h0000_4000);
    check("rr_write", dfp_write, 1);
    check("rr_read",  dfp_read, 0);
    step();
    check("rr_mid_addr",  dfp_addr, 32'h0000_4000);
    check("rr_mid_cresp", cache_dfp_resp, 0);
    dfp_resp = 1'b1;
    settle();
    check("rr_fresp", flush_dfp_resp, 1);
    check("rr_cresp", cache_dfp_resp, 0);
    step();
    dfp_resp        = 1'b0;
    flush_dfp_write = 1'b0;
    settle();
    check("rr_c_owner", arb_owner, 0);
    check("rr_c_addr",  dfp_addr, 32'h0000_3040);
    check("rr_c_read",  dfp_read, 1);
    step();
    dfp_resp = 1'b1;
    settle();
    check("rr_c_rdata", cache_dfp_rdata, LINE_3C);
    step();
    idle_inputs();
    settle();
    check("rr_err_clean", protocol_err, 0);

    // Response while idle is dropped and flagged
    dfp_resp = 1'b1;
    settle();
    check("idle_resp_c", cache_dfp_resp, 0);
    check("idle_resp_f", flush_dfp_resp, 0);
    step();
    dfp_resp = 1'b0;
    settle();
    check("idle_resp_err", protocol_err, 1);
    step();
    check("idle_resp_sticky", protocol_err, 1);

    // Flush drops its request before response
    do_reset();
    check("drop_err_clear", protocol_err, 0);
    flush_dfp_addr  = 32'h0000_5000;
    flush_dfp_write = 1'b1;
    settle();
    check("drop_grant", arb_owner, 1);
    step();
    flush_dfp_write = 1'b0;
    settle();
    check("drop_write0", dfp_write, 0);
    check("drop_busy",   arb_busy, 1);
    check("drop_fresp",  flush_dfp_resp, 0);
    step();
    check("drop_err", protocol_err, 1);
    step();
    check("drop_sticky", protocol_err, 1);

    // Cache read and write together are forwarded and flagged
    do_reset();
    cache_dfp_addr  = 32'h0000_5500;
    cache_dfp_read  = 1'b1;
    cache_dfp_write = 1'b1;
    settle();
    check("rw_read",  dfp_read, 1);
    check("rw_write", dfp_write, 1);
    step();
    check("rw_err", protocol_err, 1);

    // Reset during BUSY_CACHE, late response, then a normal flush grant
    do_reset();
    cache_dfp_addr = 32'h0000_6000;
    cache_dfp_read = 1'b1;
    settle();
    check("mr_grant", arb_busy, 1);
    step();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    settle();
    check("mr_busy",  arb_busy, 0);
    check("mr_read",  dfp_read, 0);
    check("mr_owner", arb_owner, 0);
    check("mr_addr",  dfp_addr, 0);
    check("mr_err",   protocol_err, 0);
    dfp_resp = 1'b1;
    settle();
    check("late_cresp", cache_dfp_resp, 0);
    step();
    dfp_resp = 1'b0;
    settle();
    check("late_err", protocol_err, 1);
    flush_dfp_addr  = 32'h0000_7000;
    flush_dfp_write = 1'b1;
    settle();
    check("post_write", dfp_write, 1);
    check("post_addr",  dfp_addr, 32'h0000_7000);
    check("post_owner", arb_owner, 1);
    step();
    dfp_resp = 1'b1;
    settle();
    check("post_fresp", flush_dfp_resp, 1);
    step();
    idle_inputs();
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
